float_div16: RTL and testbench

- Iterative IEEE-754 half-precision divider, quotient = floatA / floatB.
- Inverse-direction companion to the combinational half-precision multiplier used in the conv datapath; needed for normalisation/averaging stages.
- Uses the same number conventions as the multiplier:
  - hidden-1 mantissas, no denormal handling;
  - truncation instead of rounding;
  - flush-to-zero on exponent underflow.
- Valid/ready on both sides; one operation in flight.

---
 rtl/float16_pkg.sv | 19 +
 rtl/float16_div_step.sv | 20 ++
 rtl/float_div16.sv | 169 ++++++++++++++++
 tb/tb_float_div16.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/float16_pkg.sv
// Shared half-precision field widths, constants and the divider FSM encoding.
// Imported by the divider top and its restoring-step helper.
package float16_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int EXP_BIAS = 15;

    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/float16_div_step.sv
// One combinational restoring-division step: compare, subtract, shift.
// The remainder always stays below twice the divisor, so W bits suffice.
module float16_div_step #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_mb,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic         w_ge;
    logic [W-1:0] w_diff;

    assign w_ge   = (i_rem >= i_mb);
    assign w_diff = w_ge ? (i_rem - i_mb) : i_rem;
    assign o_rem  = w_diff << 1;
    assign o_qbit = w_ge;

endmodule

// File: rtl/float_div16.sv
// Iterative half-precision divider: hidden-1 mantissas, truncation,
// flush-to-zero on underflow, saturate to infinity on overflow.
module float_div16 #(
    parameter int EXP_BIAS = float16_pkg::EXP_BIAS,
    parameter int Q_BITS   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] floatA,
    input  logic [15:0] floatB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic        div_by_zero
);

    import float16_pkg::*;

    localparam int CW = $clog2(Q_BITS);
    localparam int RW = MANT_W + 2;

    div_state_t        r_state;
    div_state_t        w_state_nxt;

    logic              r_sign;
    logic [EXP_W-1:0]  r_ea;
    logic [EXP_W-1:0]  r_eb;
    logic [RW-1:0]     r_rem;
    logic [RW-1:0]     r_mb;
    logic [Q_BITS-1:0] r_q;
    logic [CW-1:0]     r_cnt;
    logic [15:0]       r_quot;
    logic              r_dbz;
    logic              r_out_valid;

    logic              w_a_zero;
    logic              w_b_zero;
    logic              w_in_sign;
    logic [RW-1:0]     w_rem_nxt;
    logic              w_qbit;
    logic signed [6:0] w_ea7;
    logic signed [6:0] w_eb7;
    logic signed [6:0] w_exp;
    logic [MANT_W-1:0] w_mant;
    logic [15:0]       w_norm_res;

    assign w_a_zero  = (floatA[14:0] == 15'd0);
    assign w_b_zero  = (floatB[14:0] == 15'd0);
    assign w_in_sign = floatA[15] ^ floatB[15];

    float16_div_step #(
        .W (RW)
    ) u_step (
        .i_rem  (r_rem),
        .i_mb   (r_mb),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    assign w_ea7 = {2'b00, r_ea};
    assign w_eb7 = {2'b00, r_eb};

    // A quotient below 1.0 needs one extra left shift, costing one exponent step
    always_comb begin
        w_exp  = w_ea7 - w_eb7 + 7'(EXP_BIAS);
        w_mant = r_q[Q_BITS-3 -: MANT_W];
        if (r_q[Q_BITS-1]) begin
            w_mant = r_q[Q_BITS-2 -: MANT_W];
        end else begin
            w_exp = w_exp - 7'sd1;
        end
    end

    always_comb begin
        w_norm_res = {r_sign, w_exp[EXP_W-1:0], w_mant};
        if (w_exp < 7'sd0) begin
            w_norm_res = 16'h0000;
        end else if (w_exp >= 7'sd31) begin
            w_norm_res = {r_sign, POS_INF[14:0]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (w_a_zero || w_b_zero) ? DONE : DIV;
                end
            end
            DIV: begin
                if (r_cnt == CW'(Q_BITS - 1)) begin
                    w_state_nxt = NORM;
                end
            end
            NORM: w_state_nxt = DONE;
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_ea        <= '0;
            r_eb        <= '0;
            r_rem       <= '0;
            r_mb        <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quot      <= 16'h0000;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_in_sign;
                        r_ea   <= floatA[14:10];
                        r_eb   <= floatB[14:10];
                        r_rem  <= {1'b0, 1'b1, floatA[9:0]};
                        r_mb   <= {1'b0, 1'b1, floatB[9:0]};
                        r_q    <= '0;
                        r_cnt  <= '0;
                        // A zero divisor wins even when the dividend is zero too
                        if (w_b_zero) begin
                            r_quot <= {w_in_sign, POS_INF[14:0]};
                            r_dbz  <= 1'b1;
                        end else if (w_a_zero) begin
                            r_quot <= 16'h0000;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[Q_BITS-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                end
                NORM: begin
                    r_quot <= w_norm_res;
                    r_dbz  <= 1'b0;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_float_div16.sv
// Bench for float_div16: directed corner cases, backpressure, reset
// mid-operation and random operands against an arithmetic reference.
module tb_float_div16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] floatA;
    logic [15:0] floatB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic        div_by_zero;

    int n_chk;
    int n_fail;

    float_div16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .floatA      (floatA),
        .floatB      (floatB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Quotient taken as floor(ma * 2^11 / mb), then normalised by plain arithmetic
    function automatic void ref_div(input logic [15:0] a,
                                    input logic [15:0] b,
                                    output logic [15:0] q,
                                    output logic dz);
        int ma, mb, qq, e, mant;
        logic s;
        s  = a[15] ^ b[15];
        dz = 1'b0;
        if (b[14:0] == 15'd0) begin
            q  = {s, 5'h1F, 10'h000};
            dz = 1'b1;
        end else if (a[14:0] == 15'd0) begin
            q = 16'h0000;
        end else begin
            ma = 1024 + int'(a[9:0]);
            mb = 1024 + int'(b[9:0]);
            qq = (ma * 2048) / mb;
            e  = int'(a[14:10]) - int'(b[14:10]) + 15;
            if (qq >= 2048) begin
                mant = (qq / 2) % 1024;
            end else begin
                mant = qq % 1024;
                e    = e - 1;
            end
            if (e < 0) q = 16'h0000;
            else if (e >= 31) q = {s, 5'h1F, 10'h000};
            else q = {s, 5'(e), 10'(mant)};
        end
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        floatA   = a;
        floatB   = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eq,
                         input logic edz, input int elat);
        int lat;
        send(a, b);
        wait_valid(lat);
        check({tag, "/lat"}, lat, elat);
        check({tag, "/q"}, quotient, eq);
        check({tag, "/dz"}, div_by_zero, edz);
        @(posedge clk); #1;
        check({tag, "/done"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [15:0] a, b, eq;
        logic        edz;
        int          lat;
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        floatA    = 16'h0;
        floatB    = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/in_ready", in_ready, 1'b1);
        check("rst/out_valid", out_valid, 1'b0);
        check("rst/q", quotient, 16'h0000);
        check("rst/dz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("3/1.5", 16'h4200, 16'h3E00, 16'h4000, 1'b0, 14);
        do_op("1/3", 16'h3C00, 16'h4200, 16'h3555, 1'b0, 14);
        do_op("-6/2", 16'hC600, 16'h4000, 16'hC200, 1'b0, 14);
        do_op("2/0", 16'h4000, 16'h0000, 16'h7C00, 1'b1, 1);
        do_op("0/2", 16'h0000, 16'h4000, 16'h0000, 1'b0, 1);
        do_op("-0/0", 16'h8000, 16'h0000, 16'hFC00, 1'b1, 1);
        do_op("uflow", 16'h0400, 16'h7800, 16'h0000, 1'b0, 14);
        do_op("oflow", 16'h7800, 16'h0400, 16'h7C00, 1'b0, 14);

        // Backpressure: result must hold while busy inputs are ignored
        out_ready = 1'b0;
        send(16'h3C00, 16'h4200);
        wait_valid(lat);
        check("bp/lat", lat, 14);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            floatA   = 16'h4000;
            floatB   = 16'h0000;
            @(posedge clk); #1;
            check("bp/q", quotient, 16'h3555);
            check("bp/hold", {out_valid, in_ready, div_by_zero}, 3'b100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp/release", {out_valid, in_ready}, 2'b01);
        check("bp/q_kept", quotient, 16'h3555);
        @(posedge clk); #1;
        check("bp/no_extra", out_valid, 1'b0);

        // Reset while dividing discards the operation
        send(16'h4200, 16'h3E00);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rmid/state", {in_ready, out_valid}, 2'b10);
        check("rmid/q", quotient, 16'h0000);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rmid/quiet", out_valid, 1'b0);
        do_op("rmid/fresh", 16'h4200, 16'h3E00, 16'h4000, 1'b0, 14);

        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(9, 0) == 0) a[14:0] = 15'd0;
            if ($urandom_range(9, 0) == 0) b[14:0] = 15'd0;
            if ($urandom_range(3, 0) == 0) begin
                a[14:10] = 5'($urandom_range(20, 10));
                b[14:10] = 5'($urandom_range(20, 10));
            end
            ref_div(a, b, eq, edz);
            do_op($sformatf("rnd %h/%h", a, b), a, b, eq, edz,
                  ((a[14:0] == 15'd0) || (b[14:0] == 15'd0)) ? 1 : 14);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
